// File: rtl/pattern_gen_anim.sv
// Test-pattern generator locked to an incoming sync stream: re-times the syncs by two
// cycles and produces colour, including a bouncing box and a scrolling checkerboard.
module pattern_gen_anim #(
  parameter int VIDEO_WIDTH   = 3,
  parameter int TOTAL_COLS    = 800,
  parameter int TOTAL_ROWS    = 525,
  parameter int ACTIVE_COLS   = 640,
  parameter int ACTIVE_ROWS   = 480,
  parameter int BOX_SIZE      = 32,
  parameter int SPEED         = 2,
  parameter int CHECKER_SHIFT = 5,
  parameter int GRAD_SHIFT    = 4
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  input  logic [3:0]             i_Pattern,
  input  logic                   i_HSync,
  input  logic                   i_VSync,
  output logic                   o_HSync,
  output logic                   o_VSync,
  output logic [VIDEO_WIDTH-1:0] o_Red_Video,
  output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
  output logic [VIDEO_WIDTH-1:0] o_Blu_Video,
  output logic                   o_Frame_Start,
  output logic [7:0]             o_Frame_Count
);

  localparam logic [11:0] C_TC_M1 = 12'(TOTAL_COLS - 1);
  localparam logic [11:0] C_TR_M1 = 12'(TOTAL_ROWS - 1);
  localparam logic [11:0] C_AC    = 12'(ACTIVE_COLS);
  localparam logic [11:0] C_AR    = 12'(ACTIVE_ROWS);
  localparam logic [11:0] C_AC_M2 = 12'(ACTIVE_COLS - 2);
  localparam logic [11:0] C_AR_M2 = 12'(ACTIVE_ROWS - 2);
  localparam logic [11:0] C_BOX   = 12'(BOX_SIZE);
  localparam logic [11:0] C_SPD   = 12'(SPEED);
  localparam logic [11:0] C_BXMAX = 12'(ACTIVE_COLS - BOX_SIZE);
  localparam logic [11:0] C_BYMAX = 12'(ACTIVE_ROWS - BOX_SIZE);
  localparam logic [11:0] C_BAR_W = 12'(ACTIVE_COLS / 8);
  localparam logic [VIDEO_WIDTH-1:0] C_ONES = '1;

  logic                   r_hs_d1, r_vs_d1;
  logic [11:0]            r_col, r_row;
  logic [3:0]             r_pattern;
  logic [7:0]             r_frame_count;
  logic [11:0]            r_box_x, r_box_y;
  logic                   r_dir_x_neg, r_dir_y_neg;

  logic                   w_frame_start;
  logic [12:0]            w_box_x_nxt, w_box_y_nxt;
  logic                   w_active, w_chk, w_chk9, w_border, w_in_box;
  logic [2:0]             w_bar;
  logic [VIDEO_WIDTH-1:0] w_grad_r, w_grad_g;
  logic [VIDEO_WIDTH-1:0] w_red, w_grn, w_blu;

  // Returns {negative_direction, position} for the next frame along one axis.
  function automatic logic [12:0] f_box_step(input logic [11:0] pos, input logic neg,
                                             input logic [11:0] act, input logic [11:0] pos_max);
    logic [12:0] reach;
    reach = {1'b0, pos} + {1'b0, C_SPD} + {1'b0, C_BOX};
    if (!neg && (reach > {1'b0, act}))  return {1'b1, pos_max};
    else if (neg && (pos < C_SPD))      return {1'b0, 12'd0};
    else if (neg)                       return {1'b1, pos - C_SPD};
    else                                return {1'b0, pos + C_SPD};
  endfunction

  assign w_frame_start = i_VSync & ~r_vs_d1;
  assign w_box_x_nxt   = f_box_step(r_box_x, r_dir_x_neg, C_AC, C_BXMAX);
  assign w_box_y_nxt   = f_box_step(r_box_y, r_dir_y_neg, C_AR, C_BYMAX);
  assign o_Frame_Count = r_frame_count;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_hs_d1 <= 1'b0;
      r_vs_d1 <= 1'b0;
      o_HSync <= 1'b0;
      o_VSync <= 1'b0;
      r_col   <= '0;
      r_row   <= '0;
    end else begin
      r_hs_d1 <= i_HSync;
      r_vs_d1 <= i_VSync;
      o_HSync <= r_hs_d1;
      o_VSync <= r_vs_d1;
      if (w_frame_start) begin
        r_col <= '0;
        r_row <= '0;
      end else if (r_col == C_TC_M1) begin
        r_col <= '0;
        r_row <= (r_row == C_TR_M1) ? 12'd0 : r_row + 12'd1;
      end else begin
        r_col <= r_col + 12'd1;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_pattern     <= '0;
      r_frame_count <= '0;
      o_Frame_Start <= 1'b0;
      r_box_x       <= '0;
      r_box_y       <= '0;
      r_dir_x_neg   <= 1'b0;
      r_dir_y_neg   <= 1'b0;
    end else begin
      o_Frame_Start <= w_frame_start;
      if (w_frame_start) begin
        r_pattern     <= i_Pattern;
        r_frame_count <= r_frame_count + 8'd1;
        {r_dir_x_neg, r_box_x} <= w_box_x_nxt;
        {r_dir_y_neg, r_box_y} <= w_box_y_nxt;
      end
    end
  end

  assign w_active = (r_col < C_AC) && (r_row < C_AR);
  assign w_chk    = r_col[CHECKER_SHIFT] ^ r_row[CHECKER_SHIFT];
  // Scrolling checker: only the checker bit of the shifted column matters.
  assign w_chk9   = 1'((r_col + {4'd0, r_frame_count}) >> CHECKER_SHIFT) ^ r_row[CHECKER_SHIFT];
  assign w_bar    = 3'(r_col / C_BAR_W);
  assign w_grad_r = VIDEO_WIDTH'(r_col >> GRAD_SHIFT);
  assign w_grad_g = VIDEO_WIDTH'(r_row >> GRAD_SHIFT);
  assign w_border = (r_row <= 12'd1) || (r_row >= C_AR_M2) ||
                    (r_col <= 12'd1) || (r_col >= C_AC_M2);
  assign w_in_box = (r_col >= r_box_x) && (r_col < r_box_x + C_BOX) &&
                    (r_row >= r_box_y) && (r_row < r_box_y + C_BOX);

  always_comb begin
    w_red = '0;
    w_grn = '0;
    w_blu = '0;
    if (w_active) begin
      case (r_pattern)
        4'd1: w_red = C_ONES;
        4'd2: w_grn = C_ONES;
        4'd3: w_blu = C_ONES;
        4'd4: if (w_chk) begin
          w_red = C_ONES; w_grn = C_ONES; w_blu = C_ONES;
        end
        4'd5: begin
          w_red = {VIDEO_WIDTH{w_bar[2]}};
          w_grn = {VIDEO_WIDTH{w_bar[1]}};
          w_blu = {VIDEO_WIDTH{w_bar[0]}};
        end
        4'd6: if (w_border) begin
          w_red = C_ONES; w_grn = C_ONES; w_blu = C_ONES;
        end
        4'd7: begin
          w_blu = C_ONES;
          if (w_in_box) begin
            w_red = C_ONES; w_grn = C_ONES;
          end
        end
        4'd8: begin
          w_red = w_grad_r;
          w_grn = w_grad_g;
        end
        4'd9: if (w_chk9) begin
          w_red = C_ONES; w_grn = C_ONES; w_blu = C_ONES;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_Red_Video <= '0;
      o_Grn_Video <= '0;
      o_Blu_Video <= '0;
    end else begin
      o_Red_Video <= w_red;
      o_Grn_Video <= w_grn;
      o_Blu_Video <= w_blu;
    end
  end

endmodule
